// File: rtl/counter_arbiter.sv
// Two-requester round-robin front end for a shared loadable up/down counter.
// Each accepted command drives the counter for N cycles, then returns a response.
module counter_arbiter (
   input  logic       CLK,
   input  logic       reset,
   input  logic [1:0] req_valid,
   output logic [1:0] req_ready,
   input  logic [1:0] req0_op,
   input  logic [1:0] req1_op,
   input  logic [3:0] req0_arg,
   input  logic [3:0] req1_arg,
   output logic       Enable,
   output logic       Load,
   output logic       Count,
   output logic [3:0] Data_in,
   input  logic [3:0] A_count,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [3:0] rsp_value,
   output logic       rsp_wrap
);

   // state  | meaning
   // IDLE   | arbitrate and accept one command
   // RUN    | drive counter controls for N cycles
   // SETTLE | counter has taken its last update; capture A_count
   // RESP   | hold response until rsp_ready
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] SETTLE = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_HOLD = 2'b11;

   logic [1:0] state_q, state_d;
   logic       last_q, last_d;
   logic       id_q, id_d;
   logic [1:0] op_q, op_d;
   logic [3:0] arg_q, arg_d;
   logic [3:0] step_q, step_d;
   logic       wrap_q, wrap_d;
   logic [3:0] value_q, value_d;
   logic       post_rst_q;

   logic [1:0] grant;
   logic       sel_id;
   logic [1:0] sel_op;
   logic [3:0] sel_arg;
   logic       run_last;
   logic       in_run;

   // last_q holds the previously granted requester; the other one wins a tie
   always_comb begin
      if (req_valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
      else                    grant = req_valid;
   end

   // The cycle after reset is kept quiet, so no accept is offered there
   assign req_ready = (state_q == IDLE && !reset && !post_rst_q) ? grant : 2'b00;
   assign sel_id    = req_ready[1];
   assign sel_op    = sel_id ? req1_op  : req0_op;
   assign sel_arg   = sel_id ? req1_arg : req0_arg;
   assign run_last  = (op_q == OP_LOAD) || (step_q == arg_q - 4'd1);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      op_d    = op_q;
      arg_d   = arg_q;
      step_d  = step_q;
      wrap_d  = wrap_q;
      value_d = value_q;
      case (state_q)
         IDLE: begin
            if (|req_ready) begin
               id_d    = sel_id;
               op_d    = sel_op;
               arg_d   = sel_arg;
               last_d  = sel_id;
               wrap_d  = 1'b0;
               step_d  = 4'd0;
               state_d = (sel_op != OP_LOAD && sel_arg == 4'd0) ? SETTLE : RUN;
            end
         end
         RUN: begin
            step_d = step_q + 4'd1;
            if ((op_q == OP_UP && A_count == 4'd15) || (op_q == OP_DOWN && A_count == 4'd0))
               wrap_d = 1'b1;
            if (run_last) state_d = SETTLE;
         end
         SETTLE: begin
            value_d = A_count;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         id_q       <= 1'b0;
         op_q       <= OP_LOAD;
         arg_q      <= 4'd0;
         step_q     <= 4'd0;
         wrap_q     <= 1'b0;
         value_q    <= 4'd0;
         post_rst_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         id_q       <= id_d;
         op_q       <= op_d;
         arg_q      <= arg_d;
         step_q     <= step_d;
         wrap_q     <= wrap_d;
         value_q    <= value_d;
         post_rst_q <= 1'b0;
      end
   end

   assign in_run    = (state_q == RUN) && !reset;
   assign Enable    = in_run && (op_q != OP_HOLD);
   assign Load      = in_run && (op_q == OP_LOAD);
   assign Count     = in_run && (op_q == OP_UP);
   assign Data_in   = Load ? arg_q : 4'd0;

   assign rsp_valid = (state_q == RESP) && !reset;
   assign rsp_id    = id_q & ~reset;
   assign rsp_wrap  = wrap_q & ~reset;
   assign rsp_value = reset ? 4'd0 : value_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: models the shared counter, queues expected
// responses at accept time and checks them when the response appears.
module tb_counter_arbiter;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_HOLD = 2'b11;

   logic       CLK = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] req_valid = 2'b00;
   logic [1:0] req_ready;
   logic [1:0] req0_op = 2'b00, req1_op = 2'b00;
   logic [3:0] req0_arg = 4'd0, req1_arg = 4'd0;
   logic       Enable, Load, Count;
   logic [3:0] Data_in;
   logic [3:0] a_cnt = 4'd0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic       rsp_id;
   logic [3:0] rsp_value;
   logic       rsp_wrap;

   int total = 0;
   int bad   = 0;
   logic [5:0] exp_q[$];

   always #5 CLK = ~CLK;

   // Shared counter the arbiter controls
   always @(posedge CLK)
      if (Enable) a_cnt <= Load ? Data_in : (Count ? a_cnt + 4'd1 : a_cnt - 4'd1);

   counter_arbiter dut (
      .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req0_op(req0_op), .req1_op(req1_op), .req0_arg(req0_arg), .req1_arg(req1_arg),
      .Enable(Enable), .Load(Load), .Count(Count), .Data_in(Data_in), .A_count(a_cnt),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_value(rsp_value), .rsp_wrap(rsp_wrap)
   );

   task automatic check(input string tag, input int obs, input int expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_zero(input string tag);
      check(tag, int'({req_ready, Enable, Load, Count, Data_in,
                       rsp_valid, rsp_id, rsp_value, rsp_wrap}), 0);
   endtask

   task automatic set_req(input int id, input logic [1:0] op, input logic [3:0] arg);
      if (id == 0) begin req0_op = op; req0_arg = arg; end
      else         begin req1_op = op; req1_arg = arg; end
      req_valid[id] = 1'b1;
   endtask

   task automatic wait_accept(input string tag, input logic [1:0] exp_ready);
      int got = 0;
      for (int w = 0; w < 30; w++) begin
         @(negedge CLK);
         if (req_ready != 2'b00) begin got = 1; break; end
         @(posedge CLK); #1;
      end
      check({tag, "_accept"}, got, 1);
      check({tag, "_grant"}, int'(req_ready), int'(exp_ready));
   endtask

   task automatic await_rsp(input logic [1:0] drop, output int lat, output int en,
                            output int ld, output int up, output int dn,
                            output logic [3:0] din);
      lat = -1; en = 0; ld = 0; up = 0; dn = 0; din = 4'd0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge CLK); #1;
         if (k == 1) req_valid = req_valid & ~drop;
         @(negedge CLK);
         if (rsp_valid) begin lat = k; break; end
         if (Enable) en++;
         if (Load) begin ld++; din = Data_in; end
         if (Enable && !Load && Count)  up++;
         if (Enable && !Load && !Count) dn++;
      end
   endtask

   task automatic pop_check(input string tag);
      logic [5:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_nonempty"}, exp_q.size(), 1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_id"},    int'(rsp_id),    int'(e[5]));
         check({tag, "_value"}, int'(rsp_value), int'(e[4:1]));
         check({tag, "_wrap"},  int'(rsp_wrap),  int'(e[0]));
      end
   endtask

   task automatic run_cmd(input int id, input logic [1:0] op, input logic [3:0] arg,
                          input logic [3:0] val, input logic wrap, input int lat,
                          input int en, input int ld, input int up, input int dn,
                          input logic [3:0] din, input string tag);
      int lat_o, en_o, ld_o, up_o, dn_o;
      logic [3:0] din_o;
      logic [1:0] er;
      er = (id == 0) ? 2'b01 : 2'b10;
      @(posedge CLK); #1;
      set_req(id, op, arg);
      wait_accept(tag, er);
      exp_q.push_back({er[1], val, wrap});
      await_rsp(er, lat_o, en_o, ld_o, up_o, dn_o, din_o);
      check({tag, "_latency"}, lat_o, lat);
      check({tag, "_enable_cycles"}, en_o, en);
      check({tag, "_load_cycles"}, ld_o, ld);
      check({tag, "_up_cycles"}, up_o, up);
      check({tag, "_down_cycles"}, dn_o, dn);
      if (ld != 0) check({tag, "_data_in"}, int'(din_o), int'(din));
      pop_check(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat_o, en_o, ld_o, up_o, dn_o;
      logic [3:0] din_o;
      logic [1:0] er;

      // Reset: outputs quiet during reset and the following cycle, even with a request up
      reset = 1'b1;
      req_valid = 2'b01;
      @(negedge CLK);
      check_zero("in_reset");
      @(posedge CLK); #1;
      reset = 1'b0;
      @(negedge CLK);
      check_zero("after_reset");
      @(posedge CLK); #1;
      req_valid = 2'b00;
      @(negedge CLK);
      check("idle_no_rsp", int'(rsp_valid), 0);

      run_cmd(0, OP_LOAD, 4'd9,  4'd9,  1'b0, 3, 1, 1, 0, 0, 4'd9,  "load9");
      run_cmd(0, OP_LOAD, 4'd14, 4'd14, 1'b0, 3, 1, 1, 0, 0, 4'd14, "load14");
      run_cmd(1, OP_UP,   4'd3,  4'd1,  1'b1, 5, 3, 0, 3, 0, 4'd0,  "up3");
      run_cmd(0, OP_LOAD, 4'd2,  4'd2,  1'b0, 3, 1, 1, 0, 0, 4'd2,  "load2");
      run_cmd(1, OP_DOWN, 4'd2,  4'd0,  1'b0, 4, 2, 0, 0, 2, 4'd0,  "down2");
      run_cmd(1, OP_DOWN, 4'd1,  4'd15, 1'b1, 3, 1, 0, 0, 1, 4'd0,  "down1");
      run_cmd(0, OP_LOAD, 4'd5,  4'd5,  1'b0, 3, 1, 1, 0, 0, 4'd5,  "load5");
      run_cmd(1, OP_HOLD, 4'd4,  4'd5,  1'b0, 6, 0, 0, 0, 0, 4'd0,  "hold4");
      run_cmd(0, OP_UP,   4'd0,  4'd5,  1'b0, 2, 0, 0, 0, 0, 4'd0,  "up0");
      run_cmd(1, OP_UP,   4'd15, 4'd4,  1'b1, 17, 15, 0, 15, 0, 4'd0, "up15");

      // Reset in the second RUN cycle of UP 8: aborted, counter advanced once
      @(posedge CLK); #1;
      set_req(0, OP_UP, 4'd8);
      wait_accept("up8", 2'b01);
      @(posedge CLK); #1;
      req_valid = 2'b00;
      @(negedge CLK);
      check("up8_run1_enable", int'(Enable), 1);
      @(posedge CLK); #1;
      reset = 1'b1;
      @(negedge CLK);
      check_zero("reset_mid_run");
      @(posedge CLK); #1;
      reset = 1'b0;
      @(negedge CLK);
      check_zero("after_mid_reset");
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         @(negedge CLK);
         check("abort_no_rsp", int'(rsp_valid), 0);
         check("abort_no_enable", int'(Enable), 0);
      end
      check("count_after_abort", int'(a_cnt), 5);

      // Both requesters held valid: grants alternate starting with requester 0
      @(posedge CLK); #1;
      req0_op = OP_UP; req0_arg = 4'd1;
      req1_op = OP_UP; req1_arg = 4'd1;
      req_valid = 2'b11;
      for (int g = 0; g < 4; g++) begin
         er = (g % 2 == 0) ? 2'b01 : 2'b10;
         wait_accept("rr", er);
         exp_q.push_back({er[1], 4'(6 + g), 1'b0});
         await_rsp((g == 3) ? 2'b11 : 2'b00, lat_o, en_o, ld_o, up_o, dn_o, din_o);
         check("rr_latency", lat_o, 3);
         check("rr_up_cycles", up_o, 1);
         pop_check("rr");
      end

      // Response stalled 3 cycles; a request raised then dropped meanwhile is cancelled
      @(posedge CLK); #1;
      rsp_ready = 1'b0;
      set_req(0, OP_LOAD, 4'd3);
      wait_accept("ld3", 2'b01);
      exp_q.push_back({1'b0, 4'd3, 1'b0});
      await_rsp(2'b01, lat_o, en_o, ld_o, up_o, dn_o, din_o);
      check("ld3_latency", lat_o, 3);
      for (int s = 0; s < 3; s++) begin
         if (s > 0) begin
            @(posedge CLK); #1;
            if (s == 1) set_req(1, OP_UP, 4'd2);
            else        req_valid = 2'b00;
            @(negedge CLK);
         end
         check("stall_valid", int'(rsp_valid), 1);
         check("stall_rsp_fields", int'({rsp_id, rsp_value, rsp_wrap}), int'({1'b0, 4'd3, 1'b0}));
         check("stall_no_ready", int'(req_ready), 0);
      end
      @(posedge CLK); #1;
      rsp_ready = 1'b1;
      @(negedge CLK);
      check("ld3_taken_valid", int'(rsp_valid), 1);
      pop_check("ld3");
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         @(negedge CLK);
         check("cancel_no_rsp", int'(rsp_valid), 0);
         check("cancel_no_enable", int'(Enable), 0);
      end
      check("count_after_cancel", int'(a_cnt), 3);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
